// File: rtl/cpu_step_sequencer_if.sv
// Timing-side bundle between the step sequencer and the microcode groups.
// The sequencer owns the slave side; the control unit or a bench drives the
// master side.
interface cpu_step_sequencer_if;
    logic       i_T_Enable;
    logic       i_Wait;
    logic       i_IR_Fetch;
    logic [7:0] i_Data_Bus;
    logic [3:0] o_Cycle_Step;
    logic [2:0] o_M_Cycle;
    logic [7:0] o_IR;
    logic       o_MiscALU_Active;
    logic       o_Opcode_Bit3;
    logic       o_Fetch_Strobe;
    logic       o_Fault;

    modport master (
        output i_T_Enable, i_Wait, i_IR_Fetch, i_Data_Bus,
        input  o_Cycle_Step, o_M_Cycle, o_IR, o_MiscALU_Active,
               o_Opcode_Bit3, o_Fetch_Strobe, o_Fault
    );

    modport slave (
        input  i_T_Enable, i_Wait, i_IR_Fetch, i_Data_Bus,
        output o_Cycle_Step, o_M_Cycle, o_IR, o_MiscALU_Active,
               o_Opcode_Bit3, o_Fetch_Strobe, o_Fault
    );
endinterface

// File: rtl/cpu_step_sequencer.sv
// T-state / M-cycle sequencer for the per-group microcode interface.
// Rotates a one-hot step, counts M-cycles, latches the opcode on a fetch
// request at the M-cycle boundary and decodes the Misc-ALU group strobe.
module cpu_step_sequencer #(
    parameter int         MCYCLE_MAX   = 6,
    parameter logic [7:0] RESET_OPCODE = 8'h00
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset_n,
    cpu_step_sequencer_if.slave  seq
);

    typedef enum logic [3:0] {
        STEP_T1 = 4'b0001,
        STEP_T2 = 4'b0010,
        STEP_T3 = 4'b0100,
        STEP_T4 = 4'b1000
    } step_t;

    localparam logic [2:0] M_LAST = 3'(MCYCLE_MAX - 1);

    step_t      step_q, step_d;
    logic [2:0] m_cycle_q, m_cycle_d;
    logic [7:0] ir_q, ir_d;
    logic       strobe_q, strobe_d;
    logic       fault_q, fault_d;

    logic       boundary;
    logic       last_mcycle;
    logic       load_ir;

    // State register: every piece of sequencer state, aborted by reset.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, avoiding simulation races.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            step_q    <= STEP_T1;
            m_cycle_q <= 3'd0;
            ir_q      <= RESET_OPCODE;
            strobe_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            step_q    <= step_d;
            m_cycle_q <= m_cycle_d;
            ir_q      <= ir_d;
            strobe_q  <= strobe_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state logic: step rotation, wait hold and M-cycle boundary actions.
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        step_d      = step_q;
        m_cycle_d   = m_cycle_q;
        ir_d        = ir_q;
        strobe_d    = 1'b0;
        fault_d     = fault_q;

        boundary    = seq.i_T_Enable && (step_q == STEP_T4) && !seq.i_Wait;
        last_mcycle = (m_cycle_q == M_LAST);
        load_ir     = boundary && (seq.i_IR_Fetch || last_mcycle);

        if (seq.i_T_Enable) begin
            case (step_q)
                STEP_T1: step_d = STEP_T2;
                STEP_T2: step_d = STEP_T3;
                STEP_T3: step_d = STEP_T4;
                STEP_T4: step_d = seq.i_Wait ? STEP_T4 : STEP_T1;
                default: step_d = STEP_T1;
            endcase
        end

        if (load_ir) begin
            // Requested fetch, or a runaway instruction forced back to fetch.
            ir_d      = seq.i_Data_Bus;
            m_cycle_d = 3'd0;
            strobe_d  = 1'b1;
            if (!seq.i_IR_Fetch) begin
                fault_d = 1'b1;
            end
        end else if (boundary) begin
            // Cannot pass M_LAST: that case is always taken by load_ir above.
            m_cycle_d = m_cycle_q + 3'd1;
        end
    end

    // Output logic: registered state plus the combinational group decode.
    always_comb begin
        seq.o_Cycle_Step     = step_q;
        seq.o_M_Cycle        = m_cycle_q;
        seq.o_IR             = ir_q;
        seq.o_Fetch_Strobe   = strobe_q;
        seq.o_Fault          = fault_q;
        seq.o_Opcode_Bit3    = ir_q[3];
        // 27/2F/37/3F, only in the first M-cycle of the instruction.
        seq.o_MiscALU_Active = (ir_q[7:5] == 3'b001) && (ir_q[2:0] == 3'b111)
                               && (m_cycle_q == 3'd0);
    end

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed bench for cpu_step_sequencer: rotation, decode, M-cycle count,
// wait hold, forced fetch/fault, async reset and enable gating.
module tb_cpu_step_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] cur_ir;
    logic       cur_act;
    logic       cur_b3;

    cpu_step_sequencer_if seq_if ();

    cpu_step_sequencer #(
        .MCYCLE_MAX   (6),
        .RESET_OPCODE (8'h00)
    ) dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .seq       (seq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full M-cycle from step 0001; expectations describe the state after
    // the boundary clock.
    task automatic run_mcycle(input bit fetch, input logic [7:0] data,
                              input logic [2:0] exp_m, input bit exp_load,
                              input bit exp_act, input bit exp_b3);
        logic [3:0] exp_step;
        logic [7:0] exp_ir;
        seq_if.i_IR_Fetch = fetch;
        seq_if.i_Data_Bus = data;
        for (int k = 1; k < 4; k++) begin
            tick();
            exp_step = 4'b0001 << k;
            checks++;
            if (seq_if.o_Cycle_Step !== exp_step) begin
                errors++;
                $display("FAIL step: got %b expected %b", seq_if.o_Cycle_Step, exp_step);
            end
            checks++;
            if (seq_if.o_Fetch_Strobe !== 1'b0) begin
                errors++;
                $display("FAIL strobe_mid: got %b expected 0", seq_if.o_Fetch_Strobe);
            end
            checks++;
            if (seq_if.o_IR !== cur_ir) begin
                errors++;
                $display("FAIL ir_hold: got %h expected %h", seq_if.o_IR, cur_ir);
            end
            checks++;
            if ({seq_if.o_MiscALU_Active, seq_if.o_Opcode_Bit3} !== {cur_act, cur_b3}) begin
                errors++;
                $display("FAIL decode_mid: got act=%b b3=%b expected act=%b b3=%b",
                         seq_if.o_MiscALU_Active, seq_if.o_Opcode_Bit3, cur_act, cur_b3);
            end
        end
        tick();
        exp_ir = exp_load ? data : cur_ir;
        checks++;
        if (seq_if.o_Cycle_Step !== 4'b0001) begin
            errors++;
            $display("FAIL step_wrap: got %b expected 0001", seq_if.o_Cycle_Step);
        end
        checks++;
        if (seq_if.o_M_Cycle !== exp_m) begin
            errors++;
            $display("FAIL m_cycle: got %0d expected %0d", seq_if.o_M_Cycle, exp_m);
        end
        checks++;
        if (seq_if.o_Fetch_Strobe !== exp_load) begin
            errors++;
            $display("FAIL strobe_boundary: got %b expected %b", seq_if.o_Fetch_Strobe, exp_load);
        end
        checks++;
        if (seq_if.o_IR !== exp_ir) begin
            errors++;
            $display("FAIL ir_load: got %h expected %h", seq_if.o_IR, exp_ir);
        end
        checks++;
        if ({seq_if.o_MiscALU_Active, seq_if.o_Opcode_Bit3} !== {exp_act, exp_b3}) begin
            errors++;
            $display("FAIL decode: got act=%b b3=%b expected act=%b b3=%b",
                     seq_if.o_MiscALU_Active, seq_if.o_Opcode_Bit3, exp_act, exp_b3);
        end
        cur_ir  = exp_ir;
        cur_act = exp_act;
        cur_b3  = exp_b3;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (seq_if.o_Cycle_Step !== 4'b0001) begin
            errors++;
            $display("FAIL %s step: got %b expected 0001", tag, seq_if.o_Cycle_Step);
        end
        checks++;
        if (seq_if.o_M_Cycle !== 3'd0) begin
            errors++;
            $display("FAIL %s m_cycle: got %0d expected 0", tag, seq_if.o_M_Cycle);
        end
        checks++;
        if (seq_if.o_IR !== 8'h00) begin
            errors++;
            $display("FAIL %s ir: got %h expected 00", tag, seq_if.o_IR);
        end
        checks++;
        if ({seq_if.o_Fetch_Strobe, seq_if.o_Fault, seq_if.o_MiscALU_Active} !== 3'b000) begin
            errors++;
            $display("FAIL %s flags: got strobe=%b fault=%b act=%b expected 0 0 0", tag,
                     seq_if.o_Fetch_Strobe, seq_if.o_Fault, seq_if.o_MiscALU_Active);
        end
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        seq_if.i_T_Enable = 1'b0;
        seq_if.i_Wait     = 1'b0;
        seq_if.i_IR_Fetch = 1'b0;
        seq_if.i_Data_Bus = 8'h00;
        #12;
        check_reset_values("reset");
        rst_n   = 1'b1;
        cur_ir  = 8'h00;
        cur_act = 1'b0;
        cur_b3  = 1'b0;
    endtask

    task automatic test_rotation_fetch();
        seq_if.i_T_Enable = 1'b1;
        run_mcycle(1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        run_mcycle(1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_decode();
        run_mcycle(1'b1, 8'h2F, 3'd0, 1'b1, 1'b1, 1'b1);
        run_mcycle(1'b1, 8'h27, 3'd0, 1'b1, 1'b1, 1'b0);
        run_mcycle(1'b1, 8'h37, 3'd0, 1'b1, 1'b1, 1'b0);
        run_mcycle(1'b1, 8'h3F, 3'd0, 1'b1, 1'b1, 1'b1);
        run_mcycle(1'b1, 8'h3E, 3'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_mcycle_count();
        run_mcycle(1'b1, 8'h27, 3'd0, 1'b1, 1'b1, 1'b0);
        run_mcycle(1'b0, 8'hFF, 3'd1, 1'b0, 1'b0, 1'b0);
        run_mcycle(1'b0, 8'hFF, 3'd2, 1'b0, 1'b0, 1'b0);
        run_mcycle(1'b0, 8'hFF, 3'd3, 1'b0, 1'b0, 1'b0);
        run_mcycle(1'b1, 8'h3E, 3'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_wait();
        seq_if.i_IR_Fetch = 1'b1;
        seq_if.i_Data_Bus = 8'h37;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (seq_if.o_Cycle_Step !== 4'b1000) begin
            errors++;
            $display("FAIL wait_entry: got %b expected 1000", seq_if.o_Cycle_Step);
        end
        seq_if.i_Wait = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({seq_if.o_Cycle_Step, seq_if.o_Fetch_Strobe, seq_if.o_IR} !== {4'b1000, 1'b0, 8'h3E}) begin
                errors++;
                $display("FAIL wait_hold: got step=%b strobe=%b ir=%h expected 1000 0 3e",
                         seq_if.o_Cycle_Step, seq_if.o_Fetch_Strobe, seq_if.o_IR);
            end
        end
        seq_if.i_Wait = 1'b0;
        tick();
        checks++;
        if ({seq_if.o_Cycle_Step, seq_if.o_Fetch_Strobe, seq_if.o_IR, seq_if.o_M_Cycle}
            !== {4'b0001, 1'b1, 8'h37, 3'd0}) begin
            errors++;
            $display("FAIL wait_release: got step=%b strobe=%b ir=%h m=%0d expected 0001 1 37 0",
                     seq_if.o_Cycle_Step, seq_if.o_Fetch_Strobe, seq_if.o_IR, seq_if.o_M_Cycle);
        end
        cur_ir  = 8'h37;
        cur_act = 1'b1;
        cur_b3  = 1'b0;
    endtask

    task automatic test_fault_and_async_reset();
        for (int i = 1; i <= 5; i++) begin
            run_mcycle(1'b0, 8'h2F, 3'(i), 1'b0, 1'b0, 1'b0);
            checks++;
            if (seq_if.o_Fault !== 1'b0) begin
                errors++;
                $display("FAIL fault_early: got %b expected 0 at m=%0d", seq_if.o_Fault, i);
            end
        end
        run_mcycle(1'b0, 8'h2F, 3'd0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (seq_if.o_Fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_set: got %b expected 1", seq_if.o_Fault);
        end
        run_mcycle(1'b0, 8'h2F, 3'd1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (seq_if.o_Fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: got %b expected 1", seq_if.o_Fault);
        end
        tick();
        tick();
        checks++;
        if (seq_if.o_Cycle_Step !== 4'b0100) begin
            errors++;
            $display("FAIL pre_reset_step: got %b expected 0100", seq_if.o_Cycle_Step);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        #2;
        rst_n   = 1'b1;
        cur_ir  = 8'h00;
        cur_act = 1'b0;
        cur_b3  = 1'b0;
    endtask

    task automatic test_enable_toggle();
        logic [3:0] exp_step   [8] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                       4'b1000, 4'b1000, 4'b0001, 4'b0001};
        logic       exp_strobe [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        seq_if.i_IR_Fetch = 1'b1;
        seq_if.i_Data_Bus = 8'h3F;
        for (int i = 0; i < 8; i++) begin
            seq_if.i_T_Enable = (i % 2 == 0);
            tick();
            checks++;
            if ({seq_if.o_Cycle_Step, seq_if.o_Fetch_Strobe} !== {exp_step[i], exp_strobe[i]}) begin
                errors++;
                $display("FAIL enable_toggle[%0d]: got step=%b strobe=%b expected %b %b", i,
                         seq_if.o_Cycle_Step, seq_if.o_Fetch_Strobe, exp_step[i], exp_strobe[i]);
            end
        end
        checks++;
        if (seq_if.o_IR !== 8'h3F) begin
            errors++;
            $display("FAIL enable_ir: got %h expected 3f", seq_if.o_IR);
        end
        seq_if.i_T_Enable = 1'b1;
    endtask

    task automatic test_fetch_ignored();
        seq_if.i_IR_Fetch = 1'b1;
        seq_if.i_Data_Bus = 8'h27;
        for (int k = 0; k < 3; k++) tick();
        seq_if.i_IR_Fetch = 1'b0;
        tick();
        checks++;
        if ({seq_if.o_Cycle_Step, seq_if.o_M_Cycle, seq_if.o_Fetch_Strobe, seq_if.o_IR}
            !== {4'b0001, 3'd1, 1'b0, 8'h3F}) begin
            errors++;
            $display("FAIL fetch_ignored: got step=%b m=%0d strobe=%b ir=%h expected 0001 1 0 3f",
                     seq_if.o_Cycle_Step, seq_if.o_M_Cycle, seq_if.o_Fetch_Strobe, seq_if.o_IR);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rotation_fetch();
        test_decode();
        test_mcycle_count();
        test_wait();
        test_fault_and_async_reset();
        test_enable_toggle();
        test_fetch_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
